// File: rtl/ad_aes_sched.sv
// ad_aes_sched: paces light-sensor ADC conversions and packs 16 consecutive
// 8-bit samples into 128-bit plaintext blocks for the AES core.
//
// Flow: wait for a loaded key, collect a block, offer it over valid/ready,
// then wait for the AES core to finish before collecting the next block.
// Samples that arrive while a block is offered or being encrypted are dropped.
//
// Build option: define OVERRUN_CNT_EN to enable the sticky overrun flag and
// the drop_cnt output. Without it, overrun is tied low and drops are silent.
module ad_aes_sched #(
  parameter int unsigned SAMPLE_DIV      = 8,   // clocks per sample period, 4..255
  parameter int unsigned SAMPLES_PER_BLK = 16   // bytes per block
) (
  input  logic                         ADC_CLK_90,
  input  logic                         rst,
  input  logic                         locked,
  input  logic                         KEY_DONE,
  input  logic [7:0]                   ad_data,
  output logic                         ADC_EN_N,
  output logic [8*SAMPLES_PER_BLK-1:0] blk_data,
  output logic                         blk_valid,
  input  logic                         blk_ready,
  input  logic                         aes_done,
  output logic                         busy,
  output logic [15:0]                  blk_cnt,
  output logic                         overrun
`ifdef OVERRUN_CNT_EN
  ,
  output logic [15:0]                  drop_cnt
`endif
);

  localparam int unsigned IdxW = $clog2(SAMPLES_PER_BLK);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(SAMPLES_PER_BLK - 1);
  localparam logic [7:0] DivLast = 8'(SAMPLE_DIV - 1);
  localparam logic [7:0] DivConv = 8'(SAMPLE_DIV - 2);

  typedef enum logic [1:0] {
    StIdle,
    StSample,
    StIssue,
    StWaitAes
  } state_e;

  state_e                         state_q, state_d;
  logic [7:0]                     div_cnt_q, div_cnt_d;
  logic [IdxW-1:0]                idx_q, idx_d;
  logic [8*SAMPLES_PER_BLK-1:0]   data_q, data_d;
  logic [15:0]                    cnt_q, cnt_d;
  logic                           key_ok_q, key_ok_d;

  logic div_run;
  logic capture;

  // Divider advances only while active and the clock wizard is locked.
  always_comb begin
    div_run = (state_q != StIdle) && locked;
    capture = div_run && (div_cnt_q == DivLast);
  end

  // Next-state logic for the sequencer, divider, packer and block counter.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    key_ok_d  = key_ok_q | (KEY_DONE & locked);

    if (div_run) begin
      div_cnt_d = (div_cnt_q == DivLast) ? 8'd0 : div_cnt_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (key_ok_q && locked) begin
          state_d = StSample;
          idx_d   = '0;
        end
      end
      StSample: begin
        if (capture) begin
          // First sample of a block lands in the least significant byte.
          data_d[{idx_q, 3'b000} +: 8] = ad_data;
          if (idx_q == IdxLast) begin
            state_d = StIssue;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StIssue: begin
        if (blk_ready) begin
          state_d = StWaitAes;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      StWaitAes: begin
        // Divider keeps its phase; the next capture becomes byte 0.
        if (aes_done) begin
          state_d = StSample;
          idx_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state; synchronous reset drops any partial block.
  always_ff @(posedge ADC_CLK_90) begin
    if (rst) begin
      state_q   <= StIdle;
      div_cnt_q <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      key_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      key_ok_q  <= key_ok_d;
    end
  end

`ifdef OVERRUN_CNT_EN
  logic        drop;
  logic        overrun_q;
  logic [15:0] drop_cnt_q;

  // A capture outside SAMPLE (including one coinciding with aes_done) is lost.
  always_comb begin
    drop = capture && ((state_q == StIssue) || (state_q == StWaitAes));
  end

  // Sticky overrun flag and saturating count of dropped samples.
  always_ff @(posedge ADC_CLK_90) begin
    if (rst) begin
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overrun_q <= 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign overrun  = overrun_q;
  assign drop_cnt = drop_cnt_q;
`else
  assign overrun = 1'b0;
`endif

  // Conversion strobe one clock ahead of the capture edge; pauses with locked.
  assign ADC_EN_N  = div_run && (div_cnt_q == DivConv);
  assign blk_data  = data_q;
  assign blk_valid = (state_q == StIssue);
  assign busy      = (state_q != StIdle);
  assign blk_cnt   = cnt_q;

endmodule

// File: tb/tb_ad_aes_sched.sv
// Bench for ad_aes_sched: directed block scenarios from a table, a reset
// corner case, then randomized traffic checked every cycle against a
// behavioural model of the sampling/packing/handshake rules.
module tb_ad_aes_sched;

  localparam int DIV = 8;

  logic         clk = 1'b0;
  logic         rst, locked, key_done, blk_ready, aes_done;
  logic [7:0]   ad;
  logic         en, valid, busy, overrun;
  logic [127:0] data;
  logic [15:0]  cnt;
`ifdef OVERRUN_CNT_EN
  logic [15:0]  drop;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ad_aes_sched #(
    .SAMPLE_DIV      (DIV),
    .SAMPLES_PER_BLK (16)
  ) dut (
    .ADC_CLK_90 (clk),
    .rst        (rst),
    .locked     (locked),
    .KEY_DONE   (key_done),
    .ad_data    (ad),
    .ADC_EN_N   (en),
    .blk_data   (data),
    .blk_valid  (valid),
    .blk_ready  (blk_ready),
    .aes_done   (aes_done),
    .busy       (busy),
    .blk_cnt    (cnt),
    .overrun    (overrun)
`ifdef OVERRUN_CNT_EN
    ,
    .drop_cnt   (drop)
`endif
  );

  // Behavioural model: 0 idle, 1 collecting, 2 offering, 3 awaiting AES.
  int           m_mode;
  int           m_phase;
  bit           m_key;
  byte unsigned m_bytes[$];
  logic [127:0] m_blk;
  int           m_cnt;
  bit           m_over;
  int           m_drop;

  task automatic model_step();
    bit strobe, run, old_key;
    int old_mode;
    old_mode = m_mode;
    old_key  = m_key;
    if (rst) begin
      m_mode = 0; m_phase = 0; m_key = 0; m_bytes.delete();
      m_blk = '0; m_cnt = 0; m_over = 0; m_drop = 0;
    end else begin
      run    = (old_mode != 0) && locked;
      strobe = run && (m_phase == DIV - 1);
      if (key_done && locked) m_key = 1;
      if (strobe && (old_mode == 2 || old_mode == 3)) begin
        m_over = 1;
        if (m_drop < 65535) m_drop++;
      end
      case (old_mode)
        0: if (old_key && locked) begin m_mode = 1; m_bytes.delete(); end
        1: if (strobe) begin
             m_blk[8*m_bytes.size() +: 8] = ad;
             m_bytes.push_back(ad);
             if (m_bytes.size() == 16) m_mode = 2;
           end
        2: if (blk_ready) begin m_mode = 3; m_cnt = (m_cnt + 1) % 65536; end
        3: if (aes_done) begin m_mode = 1; m_bytes.delete(); end
        default: m_mode = 0;
      endcase
      if (run) m_phase = (m_phase + 1) % DIV;
    end
  endtask

  task automatic check_outputs();
    logic exp_en;
    logic exp_over;
    bit   bad;
    exp_en = (m_mode != 0) && locked && (m_phase == DIV - 2);
`ifdef OVERRUN_CNT_EN
    exp_over = m_over;
`else
    exp_over = 1'b0;
`endif
    bad = 0;
    checks++;
    if (en !== exp_en) begin
      $display("FAIL cyc_adc_en_n t=%0t got %b exp %b", $time, en, exp_en); bad = 1;
    end
    if (valid !== (m_mode == 2)) begin
      $display("FAIL cyc_blk_valid t=%0t got %b exp %b", $time, valid, m_mode == 2); bad = 1;
    end
    if (busy !== (m_mode != 0)) begin
      $display("FAIL cyc_busy t=%0t got %b exp %b", $time, busy, m_mode != 0); bad = 1;
    end
    if (data !== m_blk) begin
      $display("FAIL cyc_blk_data t=%0t got %h exp %h", $time, data, m_blk); bad = 1;
    end
    if (cnt !== 16'(m_cnt)) begin
      $display("FAIL cyc_blk_cnt t=%0t got %0d exp %0d", $time, cnt, m_cnt); bad = 1;
    end
    if (overrun !== exp_over) begin
      $display("FAIL cyc_overrun t=%0t got %b exp %b", $time, overrun, exp_over); bad = 1;
    end
`ifdef OVERRUN_CNT_EN
    if (drop !== 16'(m_drop)) begin
      $display("FAIL cyc_drop_cnt t=%0t got %0d exp %0d", $time, drop, m_drop); bad = 1;
    end
`endif
    if (bad) errors++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0]   base;
    int           pause_at;
    int           pause_len;
    int           ready_delay;
    int           done_delay;
    logic [127:0] exp_blk;
    int           exp_cnt;
  } scen_t;

  scen_t tbl[3];

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, guard;
    bit seen, paused, stable;
    logic [127:0] held;

    tbl[0] = '{8'h00, 0, 0, 0, 3,
               128'h0F0E0D0C0B0A09080706050403020100, 1};
    tbl[1] = '{8'h10, 5, 20, 50, 40,
               128'h1F1E1D1C1B1A19181716151413121110, 2};
    tbl[2] = '{8'hA0, 10, 7, 2, 0,
               128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, 3};

    rst = 1; locked = 0; key_done = 0; ad = '0; blk_ready = 0; aes_done = 0;
    tick(); tick();
    check("rst_adc_en_n", en, 0);
    check("rst_blk_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_blk_data", data, 0);
    check("rst_blk_cnt", cnt, 0);
    check("rst_overrun", overrun, 0);

    // Locked but no key: nothing may start.
    rst = 0; locked = 1;
    pulses = 0; seen = 0;
    repeat (100) begin
      ad = 8'($urandom);
      tick();
      if (en) pulses++;
      if (busy || valid) seen = 1;
    end
    check("nokey_strobes", pulses, 0);
    check("nokey_busy_valid", seen, 0);

    key_done = 1; tick(); key_done = 0;

    for (int s = 0; s < 3; s++) begin
      blk_ready = (tbl[s].ready_delay == 0);
      guard = 0; paused = 0;
      while (m_mode != 2 && guard < 2000) begin
        if (!paused && tbl[s].pause_len > 0 && m_mode == 1 &&
            m_bytes.size() == tbl[s].pause_at) begin
          paused = 1; locked = 0; pulses = 0;
          repeat (tbl[s].pause_len) begin
            ad = 8'($urandom); tick(); guard++;
            if (en) pulses++;
          end
          check("pause_strobes", pulses, 0);
          locked = 1;
        end
        ad = (m_mode == 1) ? 8'(tbl[s].base + m_bytes.size()) : 8'($urandom);
        tick();
        guard++;
      end
      check("issue_reached", guard < 2000, 1);
      check("issue_valid", valid, 1);
      check("issue_blk_data", data, tbl[s].exp_blk);

      held = data; stable = 1;
      repeat (tbl[s].ready_delay) begin
        ad = 8'($urandom); tick();
        if (!valid || data !== held) stable = 0;
      end
      check("hold_stable", stable, 1);
      blk_ready = 1; ad = 8'($urandom); tick(); blk_ready = 0;
      check("xfer_blk_cnt", cnt, 16'(tbl[s].exp_cnt));
      check("xfer_valid_low", valid, 0);
      check("xfer_busy", busy, 1);

      repeat (tbl[s].done_delay) begin ad = 8'($urandom); tick(); end
      aes_done = 1; ad = 8'($urandom); tick(); aes_done = 0;
`ifdef OVERRUN_CNT_EN
      if (tbl[s].done_delay >= 40) begin
        check("late_done_overrun", overrun, 1);
        check("late_done_drop_cnt", drop, 16'(m_drop));
      end
`else
      check("overrun_tied", overrun, 0);
`endif
    end

    // Reset while a block is offered.
    blk_ready = 0; guard = 0;
    while (m_mode != 2 && guard < 2000) begin ad = 8'($urandom); tick(); guard++; end
    check("rst_issue_reached", valid, 1);
    rst = 1; tick(); rst = 0;
    check("rst_issue_valid", valid, 0);
    check("rst_issue_cnt", cnt, 0);
    check("rst_issue_busy", busy, 0);
    seen = 0;
    repeat (30) begin tick(); if (busy) seen = 1; end
    check("rst_needs_key", seen, 0);

    // Randomized traffic against the model.
    repeat (3000) begin
      rst       = ($urandom % 1000) == 0;
      locked    = ($urandom % 8) != 0;
      key_done  = ($urandom % 40) == 0;
      blk_ready = ($urandom % 3) == 0;
      aes_done  = ($urandom % 12) == 0;
      ad        = 8'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
